// File: rtl/feistel_decrypt.sv
// feistel_decrypt: Blowfish block decryption engine for the bcrypt datapath.
//
// Runs 16 Feistel rounds with the P-array consumed in reverse order (P17..P2),
// then applies the P1/P0 output whitening. S-box and P-array words come from
// two single-port synchronous SRAMs (A and B) with identical contents and
// one-cycle read latency. Each round is five cycles, so a block completes in
// 83 cycles after the accepting edge, including a one-cycle done pulse.
//
// Optional feature macro: FEISTEL_DEC_ENC_MODE_EN
//   When defined, adds input 'encrypt'. If it is high on the accepting edge,
//   the block runs forward Blowfish (P0..P15, then P16/P17 whitening) with
//   identical latency.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 launch request, sampled only in IDLE
//   L, R                  ciphertext halves, latched on the accepting edge
//   data_out_a/_b         SRAM A/B read data (valid one cycle after address)
//   addr_a/_b             SRAM A/B word addresses (0 when not selected)
//   cs_a_l/_b_l           active-low chip selects
//   we_a_l/_b_l           write enables, tied inactive (read-only master)
//   oe_a_l/_b_l           output enables, tied active
//   resultL, resultR      plaintext halves, held until the next block completes
//   done                  one-cycle pulse when results are valid
//   busy                  high in every state except IDLE
module feistel_decrypt #(
    parameter int unsigned P_ARRAY_OFFSET = 4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef FEISTEL_DEC_ENC_MODE_EN
    input  logic        encrypt,
`endif
    input  logic [31:0] L,
    input  logic [31:0] R,
    input  logic [31:0] data_out_a,
    input  logic [31:0] data_out_b,
    output logic [11:0] addr_a,
    output logic [11:0] addr_b,
    output logic        cs_a_l,
    output logic        cs_b_l,
    output logic        we_a_l,
    output logic        we_b_l,
    output logic        oe_a_l,
    output logic        oe_b_l,
    output logic [31:0] resultL,
    output logic [31:0] resultR,
    output logic        done,
    output logic        busy
);

    localparam logic [11:0] POff = 12'(P_ARRAY_OFFSET);

    typedef enum logic [3:0] {
        StIdle,
        StPFetch,
        StPXor,
        StS01,
        StS23,
        StRound,
        StFFetch,
        StFinal,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] xl_q, xl_d;
    logic [31:0] xr_q, xr_d;
    logic [31:0] f_q, f_d;
    logic [4:0]  i_q, i_d;
    logic [31:0] result_l_q, result_l_d;
    logic [31:0] result_r_q, result_r_d;
    logic        enc_q, enc_d;
    logic        enc_in;
    logic        last_round;

`ifdef FEISTEL_DEC_ENC_MODE_EN
    assign enc_in = encrypt;
`else
    assign enc_in = 1'b0;
`endif

    // Decryption walks P17 down to P2; encryption walks P0 up to P15.
    assign last_round = enc_q ? (i_q == 5'd15) : (i_q == 5'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            xl_q       <= '0;
            xr_q       <= '0;
            f_q        <= '0;
            i_q        <= '0;
            result_l_q <= '0;
            result_r_q <= '0;
            enc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            xl_q       <= xl_d;
            xr_q       <= xr_d;
            f_q        <= f_d;
            i_q        <= i_d;
            result_l_q <= result_l_d;
            result_r_q <= result_r_d;
            enc_q      <= enc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        xl_d       = xl_q;
        xr_d       = xr_q;
        f_d        = f_q;
        i_d        = i_q;
        result_l_d = result_l_q;
        result_r_d = result_r_q;
        enc_d      = enc_q;
        addr_a     = '0;
        addr_b     = '0;
        cs_a_l     = 1'b1;
        cs_b_l     = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    xl_d    = L;
                    xr_d    = R;
                    enc_d   = enc_in;
                    i_d     = enc_in ? 5'd0 : 5'd17;
                    state_d = StPFetch;
                end
            end
            StPFetch: begin
                addr_a  = POff + {7'd0, i_q};
                cs_a_l  = 1'b0;
                state_d = StPXor;
            end
            StPXor: begin
                xl_d    = xl_q ^ data_out_a;
                state_d = StS01;
            end
            StS01: begin
                addr_a  = {4'd0, xl_q[31:24]};
                addr_b  = 12'd256 + {4'd0, xl_q[23:16]};
                cs_a_l  = 1'b0;
                cs_b_l  = 1'b0;
                state_d = StS23;
            end
            StS23: begin
                f_d     = data_out_a + data_out_b;
                addr_a  = 12'd512 + {4'd0, xl_q[15:8]};
                addr_b  = 12'd768 + {4'd0, xl_q[7:0]};
                cs_a_l  = 1'b0;
                cs_b_l  = 1'b0;
                state_d = StRound;
            end
            StRound: begin
                // F completes here: ((S0 + S1) ^ S2) + S3, folded with the swap.
                xl_d = xr_q ^ ((f_q ^ data_out_a) + data_out_b);
                xr_d = xl_q;
                if (last_round) begin
                    state_d = StFFetch;
                end else begin
                    i_d     = enc_q ? (i_q + 5'd1) : (i_q - 5'd1);
                    state_d = StPFetch;
                end
            end
            StFFetch: begin
                addr_a  = POff + (enc_q ? 12'd16 : 12'd1);
                addr_b  = POff + (enc_q ? 12'd17 : 12'd0);
                cs_a_l  = 1'b0;
                cs_b_l  = 1'b0;
                state_d = StFinal;
            end
            StFinal: begin
                // Crossing xr/xl here undoes the swap of the last round.
                result_l_d = xr_q ^ data_out_b;
                result_r_d = xl_q ^ data_out_a;
                state_d    = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign resultL = result_l_q;
    assign resultR = result_r_q;
    assign done    = (state_q == StDone);
    assign busy    = (state_q != StIdle);
    assign we_a_l  = 1'b1;
    assign we_b_l  = 1'b1;
    assign oe_a_l  = 1'b0;
    assign oe_b_l  = 1'b0;

endmodule

// File: tb/tb_feistel_decrypt.sv
// Self-checking bench for feistel_decrypt: zero-S-box vector table, random
// S/P tables against a plain Blowfish model, address trace, start-while-busy,
// mid-block reset and back-to-back launch.
module tb_feistel_decrypt;

    localparam int Off = 4000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] L, R;
    logic [31:0] data_out_a, data_out_b;
    logic [11:0] addr_a, addr_b;
    logic        cs_a_l, cs_b_l, we_a_l, we_b_l, oe_a_l, oe_b_l;
    logic [31:0] resultL, resultR;
    logic        done, busy;
`ifdef FEISTEL_DEC_ENC_MODE_EN
    logic        encrypt;
`endif

    feistel_decrypt #(.P_ARRAY_OFFSET(Off)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef FEISTEL_DEC_ENC_MODE_EN
        .encrypt    (encrypt),
`endif
        .L          (L),
        .R          (R),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .cs_a_l     (cs_a_l),
        .cs_b_l     (cs_b_l),
        .we_a_l     (we_a_l),
        .we_b_l     (we_b_l),
        .oe_a_l     (oe_a_l),
        .oe_b_l     (oe_b_l),
        .resultL    (resultL),
        .resultR    (resultR),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both SRAMs hold the same image; one-cycle synchronous read.
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (!cs_a_l) data_out_a <= mem[addr_a];
        if (!cs_b_l) data_out_b <= mem[addr_b];
    end

    int checks = 0;
    int failures = 0;

    // Address trace capture.
    logic   trace_en = 1'b0;
    int     a_q[$];
    int     b_q[$];
    int     exp_a[$];
    int     exp_b[$];
    int     we_bad = 0;
    always @(negedge clk) begin
        if (!we_a_l || !we_b_l) we_bad++;
        if (trace_en) begin
            if (!cs_a_l) a_q.push_back(int'(addr_a));
            if (!cs_b_l) b_q.push_back(int'(addr_b));
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] bf_f(input logic [31:0] x);
        return ((mem[int'(x[31:24])] + mem[256 + int'(x[23:16])]) ^ mem[512 + int'(x[15:8])])
               + mem[768 + int'(x[7:0])];
    endfunction

    // Reference Blowfish decryption; also builds the expected SRAM trace.
    task automatic model_dec(input logic [31:0] l, input logic [31:0] r,
                             output logic [31:0] ol, output logic [31:0] orr);
        logic [31:0] xl, xr, t;
        xl = l;
        xr = r;
        exp_a.delete();
        exp_b.delete();
        for (int k = 17; k >= 2; k--) begin
            exp_a.push_back(Off + k);
            xl = xl ^ mem[Off + k];
            exp_a.push_back(int'(xl[31:24]));
            exp_b.push_back(256 + int'(xl[23:16]));
            exp_a.push_back(512 + int'(xl[15:8]));
            exp_b.push_back(768 + int'(xl[7:0]));
            xr = xr ^ bf_f(xl);
            t = xl; xl = xr; xr = t;
        end
        exp_a.push_back(Off + 1);
        exp_b.push_back(Off + 0);
        t = xl; xl = xr; xr = t;
        xr = xr ^ mem[Off + 1];
        xl = xl ^ mem[Off + 0];
        ol = xl;
        orr = xr;
    endtask

    task automatic model_enc(input logic [31:0] l, input logic [31:0] r,
                             output logic [31:0] ol, output logic [31:0] orr);
        logic [31:0] xl, xr, t;
        xl = l;
        xr = r;
        for (int k = 0; k < 16; k++) begin
            xl = xl ^ mem[Off + k];
            xr = xr ^ bf_f(xl);
            t = xl; xl = xr; xr = t;
        end
        t = xl; xl = xr; xr = t;
        xr = xr ^ mem[Off + 16];
        xl = xl ^ mem[Off + 17];
        ol = xl;
        orr = xr;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 1024; k++) mem[k] = $urandom;
        for (int k = 0; k < 18; k++) mem[Off + k] = $urandom;
    endtask

    // Launch one block; optional stray start pulse at cycle 'glitch'.
    task automatic run_block(input logic [31:0] l, input logic [31:0] r, input int glitch,
                             output logic [31:0] rl, output logic [31:0] rr, output int lat);
        @(posedge clk); #1;
        L = l; R = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        L = $urandom; R = $urandom;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == glitch) start = 1'b1;
            else if (glitch != 0 && n == glitch + 1) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        rl = resultL;
        rr = resultR;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end else begin
            @(posedge clk); #1;
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("busy_after_done", {31'd0, busy}, 32'd0);
            check("result_l_held", resultL, rl);
        end
    endtask

    typedef struct {
        logic [31:0] l, r, p0, p1, exp_l, exp_r;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] rl, rr, el, er, pl, pr;
        int lat, bad, dones;

        vecs[0] = '{32'h01234567, 32'h89ABCDEF, 32'h0, 32'h0, 32'h89ABCDEF, 32'h01234567};
        vecs[1] = '{32'h00000000, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'hEDCBA987, 32'h0};
        vecs[2] = '{32'hDEADBEEF, 32'h00000000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h21524110};
        vecs[3] = '{32'h11111111, 32'h22222222, 32'h0F0F0F0F, 32'hF0F0F0F0,
                    32'h2D2D2D2D, 32'hE1E1E1E1};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0,
                    32'hEDCBA987, 32'h6543210F};

        for (int k = 0; k < 4096; k++) mem[k] = '0;
        data_out_a = '0;
        data_out_b = '0;
        reset = 1'b1;
        start = 1'b0;
        L = '0;
        R = '0;
`ifdef FEISTEL_DEC_ENC_MODE_EN
        encrypt = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_resultL", resultL, 32'd0);
        check("rst_resultR", resultR, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cs", {30'd0, cs_a_l, cs_b_l}, 32'd3);
        check("rst_addr", {8'd0, addr_a, addr_b}, 32'd0);
        check("rst_we_oe", {28'd0, we_a_l, we_b_l, oe_a_l, oe_b_l}, 32'hC);
        reset = 1'b0;

        // Zero S-boxes: output is the swapped input whitened by P0/P1 only.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4096; k++) mem[k] = '0;
            mem[Off + 0] = vecs[v].p0;
            mem[Off + 1] = vecs[v].p1;
            run_block(vecs[v].l, vecs[v].r, 0, rl, rr, lat);
            check($sformatf("vec%0d_resultL", v), rl, vecs[v].exp_l);
            check($sformatf("vec%0d_resultR", v), rr, vecs[v].exp_r);
            check($sformatf("vec%0d_latency", v), lat, 32'd82);
        end

        // Random tables against the model, with full address trace on the first.
        for (int t = 0; t < 4; t++) begin
            fill_random();
            pl = $urandom;
            pr = $urandom;
            model_dec(pl, pr, el, er);
            a_q.delete();
            b_q.delete();
            trace_en = (t == 0);
            run_block(pl, pr, 0, rl, rr, lat);
            trace_en = 1'b0;
            check($sformatf("rand%0d_resultL", t), rl, el);
            check($sformatf("rand%0d_resultR", t), rr, er);
            check($sformatf("rand%0d_latency", t), lat, 32'd82);
            if (t == 0) begin
                check("trace_a_len", a_q.size(), exp_a.size());
                check("trace_b_len", b_q.size(), exp_b.size());
                bad = 0;
                for (int k = 0; k < a_q.size() && k < exp_a.size(); k++)
                    if (a_q[k] != exp_a[k]) bad++;
                for (int k = 0; k < b_q.size() && k < exp_b.size(); k++)
                    if (b_q[k] != exp_b[k]) bad++;
                check("trace_addr_mismatches", bad, 32'd0);
            end
        end

        // Stray start while busy is ignored.
        fill_random();
        pl = $urandom;
        pr = $urandom;
        model_dec(pl, pr, el, er);
        run_block(pl, pr, 10, rl, rr, lat);
        check("glitch_resultL", rl, el);
        check("glitch_resultR", rr, er);
        check("glitch_latency", lat, 32'd82);

        // Reset mid-block: idle next cycle, outputs cleared, no done.
        @(posedge clk); #1;
        L = $urandom; R = $urandom; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_resultL", resultL, 32'd0);
        check("abort_resultR", resultR, 32'd0);
        check("abort_cs", {30'd0, cs_a_l, cs_b_l}, 32'd3);
        dones = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        pl = $urandom;
        pr = $urandom;
        model_dec(pl, pr, el, er);
        run_block(pl, pr, 0, rl, rr, lat);
        check("post_abort_resultL", rl, el);
        check("post_abort_resultR", rr, er);

        // start held high across DONE -> IDLE relaunches; 84-cycle spacing.
        pl = $urandom;
        pr = $urandom;
        model_dec(pl, pr, el, er);
        @(posedge clk); #1;
        L = pl; R = pr; start = 1'b1;
        lat = -1;
        for (int n = 0; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("b2b_first_latency", lat, 32'd82);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int n = 3; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("b2b_spacing", lat, 32'd84);
        check("b2b_resultL", resultL, el);
        check("b2b_resultR", resultR, er);
        dones = 0;
        for (int n = 0; n < 90; n++) begin
            @(posedge clk); #1;
            if (busy) dones++;
        end
        check("b2b_no_third_launch", dones, 32'd0);

`ifdef FEISTEL_DEC_ENC_MODE_EN
        // Forward mode against the model, then decrypt back to the plaintext.
        fill_random();
        pl = $urandom;
        pr = $urandom;
        model_enc(pl, pr, el, er);
        encrypt = 1'b1;
        run_block(pl, pr, 0, rl, rr, lat);
        encrypt = 1'b0;
        check("enc_resultL", rl, el);
        check("enc_resultR", rr, er);
        check("enc_latency", lat, 32'd82);
        run_block(el, er, 0, rl, rr, lat);
        check("roundtrip_L", rl, pl);
        check("roundtrip_R", rr, pr);
`endif

        check("we_never_low", we_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/feistel_decrypt.md
# feistel_decrypt

Blowfish decryption core for the bcrypt datapath: the inverse of the Feistel encryption engine. It runs the 16 rounds with the P-array consumed in reverse order (P17 down to P2), then applies the P1/P0 output whitening. S-box and P-array words are read from the same two single-port synchronous SRAMs (A and B) that the encryption engine reads. Used for known-answer self-checks and for ciphertext verification paths.

## Interface
- `P_ARRAY_OFFSET`, default 4000: SRAM word address of P[0]; P[i] is at `P_ARRAY_OFFSET + i`, i = 0..17.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: sampled in IDLE only; a high sample launches one block decryption.
- `L`, `R` input 32 each: ciphertext halves, latched on the accepting edge.
- `data_out_a`, `data_out_b` input 32 each: SRAM A and SRAM B read data.
- `addr_a`, `addr_b` output 12 each: SRAM word addresses.
- `cs_a_l`, `cs_b_l` output 1 each: active-low chip selects.
- `we_a_l`, `we_b_l` output 1 each: tied to 1 (read-only master).
- `oe_a_l`, `oe_b_l` output 1 each: tied to 0.
- `resultL`, `resultR` output 32 each: plaintext halves, registered.
- `done` output 1: one-cycle pulse when `resultL` and `resultR` are valid.
- `busy` output 1: high in every state except IDLE.

## Operation
- Memory map, identical in SRAM A and B: S0 at 0–255, S1 at 256–511, S2 at 512–767, S3 at 768–1023, P at `P_ARRAY_OFFSET`+0..17.
- SRAM read latency is 1 cycle. An address presented with `cs_x_l`=0 in cycle n returns data on `data_out_x` in cycle n+1.
- Internal registers: `xl`, `xr` (32 bits each), `f` (32 bits), round index `i` (5 bits).
- State machine:
  - IDLE: when `start`=1, set `xl`<=L, `xr`<=R, `i`<=17, and go to PFETCH.
  - PFETCH: drive `addr_a` = `P_ARRAY_OFFSET`+i with `cs_a_l`=0. Go to PXOR.
  - PXOR: `xl` <= `xl` ^ `data_out_a`. Go to S01.
  - S01: drive `addr_a` = `xl[31:24]` and `addr_b` = 256+`xl[23:16]`, both chip selects low. Go to S23.
  - S23: `f` <= `data_out_a` + `data_out_b`. Drive `addr_a` = 512+`xl[15:8]` and `addr_b` = 768+`xl[7:0]`, both chip selects low. Go to ROUND.
  - ROUND: `xl` <= `xr` ^ ((`f` ^ `data_out_a`) + `data_out_b`), and `xr` <= `xl`. If i==2, go to FFETCH; otherwise `i` <= i-1 and go to PFETCH.
  - FFETCH: drive `addr_a` = `P_ARRAY_OFFSET`+1 and `addr_b` = `P_ARRAY_OFFSET`+0, both chip selects low. Go to FINAL.
  - FINAL: `resultL` <= `xr` ^ `data_out_b` and `resultR` <= `xl` ^ `data_out_a`. This undoes the last swap and applies the P0/P1 whitening. Go to DONE.
  - DONE: `done`=1. Go to IDLE.
- All additions are modulo 2^32, with carry discarded. Address additions are 12-bit and never overflow for legal offsets (`P_ARRAY_OFFSET` ≤ 4078).
- When a port is not addressed in a cycle: `cs_x_l`=1 and `addr_x`=0.

## Timing
- Reset values: `resultL`=0, `resultR`=0, `done`=0, `busy`=0, `cs_a_l`=`cs_b_l`=1, `addr_a`=`addr_b`=0. State is IDLE and all internal registers are 0.
- Latency:
  - Let edge 0 be the edge that samples `start`=1.
  - Each round takes 5 cycles, so 16 rounds take 80 cycles, followed by FFETCH and FINAL.
  - Results are registered at edge 82.
  - `done` is high for exactly the cycle between edges 82 and 83.
- `resultL` and `resultR` hold their values until the next FINAL. They stay valid after `done` falls.
- `start` is ignored while `busy`=1. `start` held high across DONE→IDLE relaunches at the first IDLE edge.
- Back-to-back throughput is one block every 84 cycles.
- `reset` asserted in any state wins over every other update. The next cycle is IDLE with all reset values, and no `done` pulse is emitted for the aborted block.

## Configuration
- `FEISTEL_DEC_ENC_MODE_EN`: when defined, adds input port `encrypt` (1 bit), which is latched on the accepting edge.
- With `encrypt`=1, the block performs forward Blowfish:
  - `i` starts at 0 and increments after each ROUND.
  - The round loop exits after i==15.
  - FFETCH addresses are `P_ARRAY_OFFSET`+16 on A and `P_ARRAY_OFFSET`+17 on B.
  - Latency is unchanged.
- With `encrypt`=0, or when the macro is undefined, the block performs decryption as specified above.
- Without the macro, the `encrypt` port does not exist.

## Test plan
- All S and P words = 0; L=0x01234567, R=0x89ABCDEF → `resultL`=0x89ABCDEF, `resultR`=0x01234567, with `done` at edge 82.
- S = 0; P[0]=0xFFFFFFFF and the rest 0; L=0, R=0x12345678 → `resultL`=0xEDCBA987, `resultR`=0.
- SRAM loaded with the Blowfish all-zero-key schedule; L=0x4EF99745, R=0x6198DD78 → `resultL`=0, `resultR`=0. With the macro defined and `encrypt`=1, input 0/0 → 0x4EF99745 / 0x6198DD78.
- Address trace: P reads occur in order offset+17, 16, …, 2, then offset+1 on A and offset+0 on B. S reads match `xl` bytes. `we_x_l` is never 0.
- Pulse `start` at cycle 10 of a run → ignored, and the result is unchanged. Assert `reset` at cycle 40 → next cycle is IDLE with outputs 0 and no `done`. A new `start` then completes normally.
